// File: rtl/bcd2bin.sv
`default_nettype none
// ============================================================================
// Module      : bcd2bin
// Description : Digit-serial BCD-to-binary converter for the stopwatch
//               time-set path. Captures nine BCD digits on start, folds them
//               MSD-first through a x10 accumulator (one digit per cycle),
//               range-checks the fields and publishes all binary fields
//               together with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd2bin (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] bcd_h_1,
    input  logic [3:0] bcd_h_0,
    input  logic [3:0] bcd_min_1,
    input  logic [3:0] bcd_min_0,
    input  logic [3:0] bcd_s_1,
    input  logic [3:0] bcd_s_0,
    input  logic [3:0] bcd_ms_2,
    input  logic [3:0] bcd_ms_1,
    input  logic [3:0] bcd_ms_0,
    output logic [6:0] bin_h,
    output logic [5:0] bin_min,
    output logic [5:0] bin_s,
    output logic [9:0] bin_ms,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_LAST_IDX = 4'd8;
    localparam logic [9:0] c_MAX_SEXA = 10'd59;

    state_t      r_state;
    // Captured digits, index 0 (h_1) in the top nibble down to index 8 (ms_0)
    logic [35:0] r_digits;
    logic [3:0]  r_idx;
    logic [9:0]  r_acc;
    logic        r_bad;
    // Minutes/seconds staged at full accumulator width so 60..99 is not
    // aliased before the range check
    logic [6:0]  r_stg_h;
    logic [9:0]  r_stg_min;
    logic [9:0]  r_stg_s;
    logic [9:0]  r_stg_ms;

    logic [3:0]  w_digit;
    logic        w_field_first;
    logic [9:0]  w_acc_base;
    logic [9:0]  w_acc_next;
    logic        w_range_bad;

    // Select the digit for the current index and note field boundaries
    always_comb begin
        w_digit       = 4'd0;
        w_field_first = 1'b0;
        case (r_idx)
            4'd0: begin w_digit = r_digits[35:32]; w_field_first = 1'b1; end
            4'd1: begin w_digit = r_digits[31:28]; end
            4'd2: begin w_digit = r_digits[27:24]; w_field_first = 1'b1; end
            4'd3: begin w_digit = r_digits[23:20]; end
            4'd4: begin w_digit = r_digits[19:16]; w_field_first = 1'b1; end
            4'd5: begin w_digit = r_digits[15:12]; end
            4'd6: begin w_digit = r_digits[11:8];  w_field_first = 1'b1; end
            4'd7: begin w_digit = r_digits[7:4];   end
            4'd8: begin w_digit = r_digits[3:0];   end
            default: begin w_digit = 4'd0; w_field_first = 1'b0; end
        endcase
    end

    // Multiply-by-10 as shift-add; the accumulator restarts on each field.
    // Wrap on invalid digits is harmless because such results are rejected.
    assign w_acc_base  = w_field_first ? 10'd0 : ((r_acc << 3) + (r_acc << 1));
    assign w_acc_next  = w_acc_base + {6'd0, w_digit};
    assign w_range_bad = (r_stg_min > c_MAX_SEXA) || (r_stg_s > c_MAX_SEXA);

    // Control FSM, digit datapath and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_digits  <= 36'd0;
            r_idx     <= 4'd0;
            r_acc     <= 10'd0;
            r_bad     <= 1'b0;
            r_stg_h   <= 7'd0;
            r_stg_min <= 10'd0;
            r_stg_s   <= 10'd0;
            r_stg_ms  <= 10'd0;
            bin_h     <= 7'd0;
            bin_min   <= 6'd0;
            bin_s     <= 6'd0;
            bin_ms    <= 10'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        r_digits <= {bcd_h_1, bcd_h_0, bcd_min_1, bcd_min_0,
                                     bcd_s_1, bcd_s_0, bcd_ms_2, bcd_ms_1,
                                     bcd_ms_0};
                        r_acc    <= 10'd0;
                        r_idx    <= 4'd0;
                        r_bad    <= 1'b0;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= CONV;
                    end
                end
                CONV: begin
                    busy  <= 1'b1;
                    r_acc <= w_acc_next;
                    if (w_digit > 4'd9) begin
                        r_bad <= 1'b1;
                    end
                    case (r_idx)
                        4'd1:    r_stg_h   <= w_acc_next[6:0];
                        4'd3:    r_stg_min <= w_acc_next;
                        4'd5:    r_stg_s   <= w_acc_next;
                        4'd8:    r_stg_ms  <= w_acc_next;
                        default: ;
                    endcase
                    if (r_idx == c_LAST_IDX) begin
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                DONE: begin
                    busy <= 1'b1;
                    done <= 1'b1;
                    if (r_bad || w_range_bad) begin
                        error <= 1'b1;
                    end else begin
                        error   <= 1'b0;
                        bin_h   <= r_stg_h;
                        bin_min <= r_stg_min[5:0];
                        bin_s   <= r_stg_s[5:0];
                        bin_ms  <= r_stg_ms;
                    end
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd2bin.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd2bin
// Description : Self-checking bench for bcd2bin. Directed time values plus
//               randomized digit sets, compared with an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd2bin;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [3:0] bcd_h_1, bcd_h_0, bcd_min_1, bcd_min_0;
    logic [3:0] bcd_s_1, bcd_s_0, bcd_ms_2, bcd_ms_1, bcd_ms_0;
    logic [6:0] bin_h;
    logic [5:0] bin_min;
    logic [5:0] bin_s;
    logic [9:0] bin_ms;
    logic       busy;
    logic       done;
    logic       error;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: what the outputs should read after each done
    int exp_h, exp_min, exp_s, exp_ms, exp_err;

    bcd2bin dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .bcd_h_1   (bcd_h_1),
        .bcd_h_0   (bcd_h_0),
        .bcd_min_1 (bcd_min_1),
        .bcd_min_0 (bcd_min_0),
        .bcd_s_1   (bcd_s_1),
        .bcd_s_0   (bcd_s_0),
        .bcd_ms_2  (bcd_ms_2),
        .bcd_ms_1  (bcd_ms_1),
        .bcd_ms_0  (bcd_ms_0),
        .bin_h     (bin_h),
        .bin_min   (bin_min),
        .bin_s     (bin_s),
        .bin_ms    (bin_ms),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Digits packed as a hex word: 36'h123456789 is 12:34:56.789
    task automatic set_digits(input logic [35:0] v);
        bcd_h_1   = v[35:32];
        bcd_h_0   = v[31:28];
        bcd_min_1 = v[27:24];
        bcd_min_0 = v[23:20];
        bcd_s_1   = v[19:16];
        bcd_s_0   = v[15:12];
        bcd_ms_2  = v[11:8];
        bcd_ms_1  = v[7:4];
        bcd_ms_0  = v[3:0];
    endtask

    // Model: decimal value of each field, reject bad digits or >59 min/sec
    task automatic model_apply(input logic [35:0] v);
        int d [9];
        int h, mi, s, ms;
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < 9; i++) begin
            d[i] = int'(v[35 - 4*i -: 4]);
            if (d[i] > 9) bad = 1'b1;
        end
        h  = d[0] * 10 + d[1];
        mi = d[2] * 10 + d[3];
        s  = d[4] * 10 + d[5];
        ms = d[6] * 100 + d[7] * 10 + d[8];
        if (bad || mi > 59 || s > 59) begin
            exp_err = 1;
        end else begin
            exp_err = 0;
            exp_h   = h;
            exp_min = mi;
            exp_s   = s;
            exp_ms  = ms;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".h"},   int'(bin_h),   exp_h);
        check({tag, ".min"}, int'(bin_min), exp_min);
        check({tag, ".s"},   int'(bin_s),   exp_s);
        check({tag, ".ms"},  int'(bin_ms),  exp_ms);
        check({tag, ".err"}, int'(error),   exp_err);
    endtask

    function automatic logic [35:0] rand_digits();
        logic [35:0] v;
        for (int i = 0; i < 9; i++) begin
            if ($urandom_range(0, 39) == 0)
                v[35 - 4*i -: 4] = 4'($urandom_range(10, 15));
            else
                v[35 - 4*i -: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    // One full conversion: start, measure latency, check results and return
    task automatic do_conv(input string tag, input logic [35:0] v);
        int lat;
        @(negedge clk);
        set_digits(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        set_digits(rand_digits());
        model_apply(v);
        check({tag, ".busy0"}, int'(busy), 1);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".latency"}, lat, 10);
        check({tag, ".busy_at_done"}, int'(busy), 1);
        check_outputs(tag);
        @(posedge clk);
        #1;
        check({tag, ".done_after"}, int'(done), 0);
        check({tag, ".busy_after"}, int'(busy), 0);
    endtask

    initial begin
        logic [35:0] v1, v2, vj;
        int ndone;

        reset_n = 1'b0;
        start   = 1'b0;
        set_digits(36'h0);
        exp_h = 0; exp_min = 0; exp_s = 0; exp_ms = 0; exp_err = 0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        check("reset.busy", int'(busy), 0);
        check("reset.done", int'(done), 0);
        @(negedge clk);
        reset_n = 1'b1;

        do_conv("nominal", 36'h123456789);
        do_conv("max",     36'h995959999);
        do_conv("zero",    36'h000000000);
        do_conv("good1",   36'h010203004);
        do_conv("baddig",  36'h010A03004);
        do_conv("recover", 36'h235900001);
        do_conv("min60",   36'h016003004);
        do_conv("s75",     36'h010275004);
        do_conv("recover2",36'h010203004);

        // Starts at edges 3 and 10 are ignored; the one at edge 11 is taken
        v1 = 36'h111111111;
        v2 = 36'h033344555;
        vj = 36'h222222222;
        ndone = 0;
        @(negedge clk);
        set_digits(v1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int e = 1; e <= 21; e++) begin
            @(negedge clk);
            start = (e == 3 || e == 10 || e == 11);
            set_digits((e == 11) ? v2 : vj);
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) ndone++;
            if (e == 10) begin
                check("busystart.done10", int'(done), 1);
                model_apply(v1);
                check_outputs("busystart.first");
            end
            if (e == 11) check("busystart.busy11", int'(busy), 1);
            if (e == 21) begin
                check("busystart.done21", int'(done), 1);
                model_apply(v2);
                check_outputs("busystart.second");
            end
        end
        check("busystart.ndone", ndone, 2);
        @(posedge clk);
        #1;
        check("busystart.idle", int'(busy), 0);

        // Asynchronous reset in the middle of a conversion
        @(negedge clk);
        set_digits(36'h987654321);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        exp_h = 0; exp_min = 0; exp_s = 0; exp_ms = 0; exp_err = 0;
        check_outputs("midreset");
        check("midreset.busy", int'(busy), 0);
        check("midreset.done", int'(done), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        for (int e = 0; e < 15; e++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("midreset.nodone", ndone, 0);

        do_conv("postreset", 36'h073015250);

        // Randomized digit sets, including occasional invalid digits
        for (int k = 0; k < 25; k++) begin
            do_conv($sformatf("rand%0d", k), rand_digits());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
